// File: rtl/dmem_arb_pkg.sv
// Shared types for the dmem arbiter: FSM state and requester ids.
// Optional statistics are enabled by DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        VID_BURST = 1'b1
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_VID = 1'b1
    } req_id_t;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(
        input logic [STAT_W-1:0] v,
        input logic              en
    );
        if (en && (v != {STAT_W{1'b1}}))
            return v + 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, video and dmem signals of the arbiter.
// slave = arbiter side, master = environment side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_wren;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_q;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_rvalid;
    logic              vid_last;
    logic [DATA_W-1:0] vid_q;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  cpu_req, cpu_wren, cpu_addr, cpu_data,
        output cpu_gnt, cpu_rvalid, cpu_q,
        input  vid_req, vid_addr,
        output vid_gnt, vid_rvalid, vid_last, vid_q,
        output mem_addr, mem_data, mem_wren,
        input  mem_q
    );

    modport master (
        output cpu_req, cpu_wren, cpu_addr, cpu_data,
        input  cpu_gnt, cpu_rvalid, cpu_q,
        output vid_req, vid_addr,
        input  vid_gnt, vid_rvalid, vid_last, vid_q,
        input  mem_addr, mem_data, mem_wren,
        output mem_q
    );

endinterface

// File: rtl/dmem_arb_burst_ctr.sv
// Video burst beat counter: latches the base, walks base+beat
// with wrap at the top of memory and flags the final beat.
module dmem_arb_burst_ctr
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int BURST_LEN = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base_in,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BURST_LEN - 1);

    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] beat_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base     <= '0;
            beat_cnt <= '0;
        end else if (start) begin
            base     <= base_in;
            beat_cnt <= ADDR_W'(1);
        end else if (advance) begin
            beat_cnt <= last ? '0 : beat_cnt + 1'b1;
        end
    end

    // Natural ADDR_W truncation gives the wrap at the top of memory.
    assign beat_addr = base + beat_cnt;
    assign last      = (beat_cnt == LAST_BEAT);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem arbiter: fixed CPU priority with a video starvation guard.
// Define DMEM_ARB_STATS_EN to add the access/stall counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 8,
    parameter int MAX_WAIT  = 3
) (
    input  logic             clock,
    input  logic             reset,
    dmem_arbiter_if.slave    bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_cpu_acc,
    output logic [STAT_W-1:0] stat_vid_bst,
    output logic [STAT_W-1:0] stat_stall
`endif
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_t            state;
    req_id_t           gnt_id;
    logic [WAIT_W-1:0] wait_cnt;
    logic              vid_win;
    logic              in_burst;
    logic [ADDR_W-1:0] beat_addr;
    logic              last;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;

    assign in_burst = (state == VID_BURST);
    assign vid_win  = bus.vid_req &&
                      (!bus.cpu_req || (wait_cnt == WAIT_MAX));

    always_comb begin
        bus.cpu_gnt = 1'b0;
        bus.vid_gnt = 1'b0;
        if (!reset && !in_burst) begin
            if (vid_win)
                bus.vid_gnt = 1'b1;
            else if (bus.cpu_req)
                bus.cpu_gnt = 1'b1;
        end
    end

    assign gnt_id = bus.vid_gnt ? REQ_VID : REQ_CPU;

    // Without a grant the bus keeps its previous address/data.
    always_comb begin
        bus.mem_addr = hold_addr;
        bus.mem_data = hold_data;
        bus.mem_wren = 1'b0;
        if (in_burst) begin
            bus.mem_addr = beat_addr;
        end else if (bus.cpu_gnt || bus.vid_gnt) begin
            case (gnt_id)
                REQ_VID: bus.mem_addr = bus.vid_addr;
                REQ_CPU: begin
                    bus.mem_addr = bus.cpu_addr;
                    bus.mem_data = bus.cpu_data;
                    bus.mem_wren = bus.cpu_wren;
                end
                default: ;
            endcase
        end
    end

    assign bus.cpu_q = bus.mem_q;
    assign bus.vid_q = bus.mem_q;

    dmem_arb_burst_ctr #(
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN)
    ) u_burst_ctr (
        .clock     (clock),
        .reset     (reset),
        .start     (bus.vid_gnt),
        .advance   (in_burst),
        .base_in   (bus.vid_addr),
        .beat_addr (beat_addr),
        .last      (last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            hold_addr      <= '0;
            hold_data      <= '0;
            bus.cpu_rvalid <= 1'b0;
            bus.vid_rvalid <= 1'b0;
            bus.vid_last   <= 1'b0;
        end else begin
            hold_addr <= bus.mem_addr;
            hold_data <= bus.mem_data;

            case (state)
                IDLE:      if (bus.vid_gnt) state <= VID_BURST;
                VID_BURST: if (last) state <= IDLE;
                default:   state <= IDLE;
            endcase

            if (bus.vid_gnt)
                wait_cnt <= '0;
            else if (bus.vid_req && (wait_cnt != WAIT_MAX))
                wait_cnt <= wait_cnt + 1'b1;

            // Read data arrives one cycle after the access edge.
            bus.cpu_rvalid <= bus.cpu_gnt && !bus.cpu_wren;
            bus.vid_rvalid <= bus.vid_gnt || in_burst;
            bus.vid_last   <= in_burst && last;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic stall;

    assign stall = (bus.cpu_req && !bus.cpu_gnt) ||
                   (bus.vid_req && !bus.vid_gnt);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_cpu_acc <= '0;
            stat_vid_bst <= '0;
            stat_stall   <= '0;
        end else begin
            stat_cpu_acc <= sat_inc(stat_cpu_acc, bus.cpu_gnt);
            stat_vid_bst <= sat_inc(stat_vid_bst, bus.vid_gnt);
            stat_stall   <= sat_inc(stat_stall, stall);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a dmem model and
// read-data scoreboard; stats checked when DMEM_ARB_STATS_EN is set.
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int BL = 8;
    localparam int MW = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_cpu_acc;
    logic [15:0] stat_vid_bst;
    logic [15:0] stat_stall;
`endif

    dmem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BURST_LEN (BL),
        .MAX_WAIT  (MW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_cpu_acc (stat_cpu_acc),
        .stat_vid_bst (stat_vid_bst),
        .stat_stall   (stat_stall)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] sh  [0:(1<<AW)-1];

    logic [DW-1:0] cpu_exp [$];
    logic [DW-1:0] vid_exp [$];
    logic          last_exp [$];
    logic [AW-1:0] addr_exp [$];

    logic [DW-1:0] mon_d;
    logic          mon_l;
    logic [AW-1:0] mon_a;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = 32'hC0DE_0000 | i;
            sh[i]  = 32'hC0DE_0000 | i;
        end
    end

    // dmem model: read-before-write, q valid the cycle after the address
    always @(posedge clock) begin
        if (bus.mem_wren)
            mem[bus.mem_addr] <= bus.mem_data;
        bus.mem_q <= mem[bus.mem_addr];
    end

    // scoreboard monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.cpu_rvalid) begin
                checks++;
                if (cpu_exp.size() == 0) begin
                    errors++;
                    $display("FAIL cpu_rvalid_unexpected got=1 want=0");
                end else begin
                    mon_d = cpu_exp.pop_front();
                    if (bus.cpu_q !== mon_d) begin
                        errors++;
                        $display("FAIL cpu_q got=%h want=%h", bus.cpu_q, mon_d);
                    end
                end
            end
            if (bus.vid_rvalid) begin
                checks++;
                if (vid_exp.size() == 0) begin
                    errors++;
                    $display("FAIL vid_rvalid_unexpected got=1 want=0");
                end else begin
                    mon_d = vid_exp.pop_front();
                    mon_l = last_exp.pop_front();
                    if (bus.vid_q !== mon_d || bus.vid_last !== mon_l) begin
                        errors++;
                        $display("FAIL vid_beat got=%h/%b want=%h/%b",
                                 bus.vid_q, bus.vid_last, mon_d, mon_l);
                    end
                end
            end else if (bus.vid_last) begin
                checks++;
                errors++;
                $display("FAIL vid_last_alone got=1 want=0");
            end
            if (bus.cpu_gnt) begin
                if (bus.cpu_wren)
                    sh[bus.cpu_addr] = bus.cpu_data;
                else
                    cpu_exp.push_back(sh[bus.cpu_addr]);
            end
            if (bus.vid_gnt) begin
                for (int i = 0; i < BL; i++) begin
                    mon_a = bus.vid_addr + AW'(i);
                    addr_exp.push_back(mon_a);
                    vid_exp.push_back(sh[mon_a]);
                    last_exp.push_back(i == BL - 1);
                end
            end
            if (addr_exp.size() != 0) begin
                mon_a = addr_exp.pop_front();
                checks++;
                if (bus.mem_addr !== mon_a || bus.mem_wren !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_mem got=%h/%b want=%h/0",
                             bus.mem_addr, bus.mem_wren, mon_a);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic flush();
        cpu_exp.delete();
        vid_exp.delete();
        last_exp.delete();
        addr_exp.delete();
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (cpu_exp.size() != 0 || vid_exp.size() != 0 || addr_exp.size() != 0) begin
            errors++;
            $display("FAIL %s_drained got=%0d/%0d/%0d want=0/0/0", name,
                     cpu_exp.size(), vid_exp.size(), addr_exp.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush();
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        bus.cpu_req  = 1'b1;
        bus.cpu_wren = 1'b1;
        bus.cpu_addr = 12'h055;
        bus.cpu_data = 32'h1234_5678;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 12'h000;
        step();
        @(negedge clock);
        checks++;
        if (bus.cpu_gnt !== 1'b0 || bus.vid_gnt !== 1'b0 || bus.mem_wren !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnts got=%b%b%b want=000",
                     bus.cpu_gnt, bus.vid_gnt, bus.mem_wren);
        end
        checks++;
        if (bus.cpu_rvalid !== 1'b0 || bus.vid_rvalid !== 1'b0 || bus.vid_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids got=%b%b%b want=000",
                     bus.cpu_rvalid, bus.vid_rvalid, bus.vid_last);
        end
        bus.cpu_req = 1'b0;
        bus.vid_req = 1'b0;
        #2 reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.cpu_gnt !== 1'b0 || bus.vid_gnt !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got=%b%b%b want=000",
                     bus.cpu_gnt, bus.vid_gnt, bus.cpu_rvalid);
        end
    endtask

    task automatic test_cpu_only();
        step();
        bus.cpu_req  = 1'b1;
        bus.cpu_wren = 1'b1;
        bus.cpu_addr = 12'h010;
        bus.cpu_data = 32'hDEAD_BEEF;
        @(negedge clock);
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.mem_wren !== 1'b1 ||
            bus.mem_addr !== 12'h010 || bus.mem_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL cpu_write got=%b%b %h %h want=11 010 deadbeef",
                     bus.cpu_gnt, bus.mem_wren, bus.mem_addr, bus.mem_data);
        end
        step();
        bus.cpu_wren = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.mem_wren !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_gnt got=%b%b%b want=100",
                     bus.cpu_gnt, bus.mem_wren, bus.cpu_rvalid);
        end
        step();
        bus.cpu_req = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_q !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL cpu_readback got=%b %h want=1 deadbeef",
                     bus.cpu_rvalid, bus.cpu_q);
        end
        step();
        @(negedge clock);
        checks++;
        if (bus.cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_rvalid_pulse got=%b want=0", bus.cpu_rvalid);
        end
        check_drained("cpu_only");
    endtask

    task automatic test_back_to_back();
        int gnts;
        gnts = 0;
        step();
        bus.cpu_req  = 1'b1;
        bus.cpu_wren = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.cpu_addr = 12'h020 + 12'(i);
            @(negedge clock);
            if (bus.cpu_gnt === 1'b1)
                gnts++;
            step();
        end
        bus.cpu_req = 1'b0;
        step();
        step();
        checks++;
        if (gnts != 5) begin
            errors++;
            $display("FAIL cpu_b2b_gnts got=%0d want=5", gnts);
        end
        check_drained("back_to_back");
    endtask

    task automatic test_burst(input logic [AW-1:0] base, input string name);
        int gcnt, rcnt, lastpos, g;
        logic [AW-1:0] seen [BL];
        logic [AW-1:0] want;
        gcnt = 0;
        rcnt = 0;
        lastpos = -1;
        g = -1;
        step();
        bus.vid_req  = 1'b1;
        bus.vid_addr = base;
        for (int c = 0; c < BL + 4; c++) begin
            @(negedge clock);
            if (bus.vid_gnt === 1'b1) begin
                gcnt++;
                g = c;
            end
            if (g >= 0 && c - g < BL)
                seen[c-g] = bus.mem_addr;
            if (bus.vid_rvalid === 1'b1) begin
                rcnt++;
                if (bus.vid_last === 1'b1)
                    lastpos = rcnt;
            end
            step();
            if (g >= 0)
                bus.vid_req = 1'b0;
        end
        bus.vid_req = 1'b0;
        checks++;
        if (gcnt != 1 || g != 0) begin
            errors++;
            $display("FAIL %s_gnt got=%0d@%0d want=1@0", name, gcnt, g);
        end
        checks++;
        if (rcnt != BL || lastpos != BL) begin
            errors++;
            $display("FAIL %s_beats got=%0d last@%0d want=%0d last@%0d",
                     name, rcnt, lastpos, BL, BL);
        end
        if (g >= 0) begin
            for (int i = 0; i < BL; i++) begin
                want = base + AW'(i);
                checks++;
                if (seen[i] !== want) begin
                    errors++;
                    $display("FAIL %s_addr%0d got=%h want=%h", name, i, seen[i], want);
                end
            end
        end
        check_drained(name);
    endtask

    task automatic test_contention();
        logic cg [MW+BL+3];
        logic vg [MW+BL+3];
        logic ecg, evg;
        step();
        bus.cpu_req  = 1'b1;
        bus.cpu_wren = 1'b0;
        bus.cpu_addr = 12'h030;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 12'h300;
        for (int c = 0; c < MW + BL + 3; c++) begin
            @(negedge clock);
            cg[c] = bus.cpu_gnt;
            vg[c] = bus.vid_gnt;
            step();
            if (vg[c] === 1'b1)
                bus.vid_req = 1'b0;
            if (c >= MW + BL)
                bus.cpu_req = 1'b0;
        end
        step();
        step();
        for (int c = 0; c <= MW + BL; c++) begin
            ecg = (c < MW) || (c == MW + BL);
            evg = (c == MW);
            checks++;
            if (cg[c] !== ecg || vg[c] !== evg) begin
                errors++;
                $display("FAIL contention_c%0d got=cpu%b vid%b want=cpu%b vid%b",
                         c, cg[c], vg[c], ecg, evg);
            end
        end
        check_drained("contention");
    endtask

    task automatic test_reset_mid_burst();
        step();
        bus.vid_req  = 1'b1;
        bus.vid_addr = 12'h200;
        @(negedge clock);
        checks++;
        if (bus.vid_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_gnt got=%b want=1", bus.vid_gnt);
        end
        step();
        bus.vid_req = 1'b0;
        step();
        step();
        step();
        #2;
        reset = 1'b1;
        flush();
        bus.cpu_req  = 1'b1;
        bus.cpu_wren = 1'b0;
        bus.cpu_addr = 12'h040;
        @(negedge clock);
        checks++;
        if (bus.vid_rvalid !== 1'b0 || bus.vid_last !== 1'b0 ||
            bus.cpu_gnt !== 1'b0 || bus.mem_wren !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs got=%b%b%b%b want=0000",
                     bus.vid_rvalid, bus.vid_last, bus.cpu_gnt, bus.mem_wren);
        end
        step();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.vid_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_cpu_gnt got=%b%b want=10",
                     bus.cpu_gnt, bus.vid_rvalid);
        end
        step();
        bus.cpu_req = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.vid_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_cpu_read got=%b%b want=10",
                     bus.cpu_rvalid, bus.vid_rvalid);
        end
        for (int i = 0; i < 4; i++) step();
        check_drained("reset_mid");
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++;
        if (stat_cpu_acc !== 16'd0 || stat_vid_bst !== 16'd0 || stat_stall !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset got=%0d/%0d/%0d want=0/0/0",
                     stat_cpu_acc, stat_vid_bst, stat_stall);
        end
        test_back_to_back();
        test_burst(12'h400, "stats_burst");
        checks++;
        if (stat_cpu_acc !== 16'd5 || stat_vid_bst !== 16'd1) begin
            errors++;
            $display("FAIL stats_counts got=%0d/%0d want=5/1",
                     stat_cpu_acc, stat_vid_bst);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cpu_req  = 1'b0;
        bus.cpu_wren = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_data = '0;
        bus.vid_req  = 1'b0;
        bus.vid_addr = '0;
        test_reset();
        test_cpu_only();
        test_back_to_back();
        test_burst(12'h100, "video");
        test_contention();
        test_burst(12'hFFC, "wrap");
        test_reset_mid_burst();
        test_burst(12'h7F9, "after_reset");
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
